// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads an instruction as two consecutive RAM bytes
// (low at pc, high at pc+1) and offers it to the decoder via valid/ready.
module instr_fetch_unit #(
  parameter int                         DATA_WIDTH    = 8,
  parameter int                         ADDRESS_WIDTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_ADDRESS = '0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          jump_valid,
  input  logic [ADDRESS_WIDTH-1:0]      jump_address,
  output logic [ADDRESS_WIDTH-1:0]      read_address,
  output logic                          Read_Enable,
  input  logic [DATA_WIDTH-1:0]         DATA_READ,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [2*DATA_WIDTH-1:0]       instruction,
  output logic [ADDRESS_WIDTH-1:0]      instr_address,
  output logic                          busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    CAPTURE  = 3'd3,
    VALID    = 3'd4
  } state_t;

  state_t                      state_q;
  logic [ADDRESS_WIDTH-1:0]    pc_q;
  logic [ADDRESS_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]       lo_q;
  logic [2*DATA_WIDTH-1:0]     instr_q;
  logic                        valid_q;
  logic [ADDRESS_WIDTH-1:0]    pc_plus1_d;
  logic [ADDRESS_WIDTH-1:0]    pc_plus2_d;

  assign pc_plus1_d = pc_q + ADDRESS_WIDTH'(1);
  assign pc_plus2_d = pc_q + ADDRESS_WIDTH'(2);

  // RAM read port is driven purely from registered state so it is glitch-free
  assign Read_Enable   = (state_q == FETCH_LO) || (state_q == FETCH_HI);
  assign read_address  = (state_q == FETCH_HI) ? pc_plus1_d : pc_q;
  assign busy          = (state_q != IDLE);
  assign instr_valid   = valid_q;
  assign instruction   = instr_q;
  assign instr_address = addr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDRESS;
      addr_q  <= RESET_ADDRESS;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (jump_valid) begin
      // A jump wins over everything; any half-fetched bytes are simply ignored
      pc_q    <= jump_address;
      valid_q <= 1'b0;
      state_q <= enable ? FETCH_LO : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_q <= FETCH_LO;
        end
        FETCH_LO: begin
          state_q <= FETCH_HI;
        end
        FETCH_HI: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          instr_q <= {DATA_READ, lo_q};
          addr_q  <= pc_q;
          valid_q <= 1'b1;
          state_q <= VALID;
        end
        VALID: begin
          if (instr_ready) begin
            pc_q    <= pc_plus2_d;
            valid_q <= 1'b0;
            state_q <= enable ? FETCH_LO : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Low-byte holding register needs no reset: it is always rewritten before use
  always_ff @(posedge clock) begin
    if (state_q == FETCH_HI) lo_q <= DATA_READ;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural RAM, directed scenarios and a
// randomized run checked by a transaction-level scoreboard.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        jump_valid;
  logic [3:0]  jump_address;
  logic [3:0]  read_address;
  logic        Read_Enable;
  logic [7:0]  DATA_READ;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [3:0]  instr_address;
  logic        busy;

  logic [7:0]  mem [16];
  int          n_chk = 0;
  int          n_pass = 0;
  int          hs_rand = 0;
  bit          rand_phase = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mpc;

  instr_fetch_unit #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RESET_ADDRESS(4'h0)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .jump_valid(jump_valid),
    .jump_address(jump_address), .read_address(read_address), .Read_Enable(Read_Enable),
    .DATA_READ(DATA_READ), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_address(instr_address), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM read port: registered data, valid the cycle after the enable is sampled
  always @(posedge clock) if (Read_Enable) DATA_READ <= mem[read_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  // Scoreboard: the model knows which pc the next accepted instruction must
  // come from; inputs are stable at the falling edge, so the values seen here
  // are exactly those the next rising edge will act on.
  always @(negedge clock) begin
    logic [3:0] a;
    logic [3:0] a1;
    if (!reset_n) begin
      exp_q.delete();
      mpc = 4'h0;
      exp_q.push_back(mpc);
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_instr", 32'(instr_address), 32'hFFFF_FFFF);
        end else begin
          a  = exp_q.pop_front();
          a1 = a + 4'd1;
          chk("sb_addr", 32'(instr_address), 32'(a));
          chk("sb_instr", 32'(instruction), 32'({mem[a1], mem[a]}));
          if (rand_phase) hs_rand++;
        end
      end
      if (jump_valid) begin
        mpc = jump_address;
        exp_q.delete();
        exp_q.push_back(mpc);
      end else if (instr_valid && instr_ready) begin
        mpc = mpc + 4'd2;
        exp_q.push_back(mpc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] held_instr;
    logic [3:0]  held_addr;

    reset_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
    jump_valid = 1'b0; jump_address = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34; mem[1] = 8'h12;
    #2;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_re", 32'(Read_Enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_raddr", 32'(read_address), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_iaddr", 32'(instr_address), 0);

    // Basic fetch and latency
    tick(); tick();
    reset_n = 1'b1; enable = 1'b1; instr_ready = 1'b1;
    tick();
    chk("f0_re", 32'(Read_Enable), 1);
    chk("f0_raddr", 32'(read_address), 0);
    chk("f0_busy", 32'(busy), 1);
    tick();
    chk("f1_re", 32'(Read_Enable), 1);
    chk("f1_raddr", 32'(read_address), 1);
    tick();
    chk("cap_re", 32'(Read_Enable), 0);
    chk("cap_valid", 32'(instr_valid), 0);
    tick();
    chk("lat_valid", 32'(instr_valid), 1);
    chk("lat_instr", 32'(instruction), 32'h1234);
    chk("lat_iaddr", 32'(instr_address), 0);
    tick();
    chk("next_valid_low", 32'(instr_valid), 0);
    chk("next_raddr", 32'(read_address), 2);
    chk("next_re", 32'(Read_Enable), 1);

    // Throughput and stall
    instr_ready = 1'b0;
    wait_valid(n);
    chk("throughput_edges", 32'(n), 3);
    held_instr = instruction;
    held_addr  = instr_address;
    chk("stall_iaddr_val", 32'(held_addr), 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", 32'(instruction), 32'(held_instr));
      chk("stall_iaddr", 32'(instr_address), 32'(held_addr));
      chk("stall_re", 32'(Read_Enable), 0);
    end
    instr_ready = 1'b1;
    tick();
    chk("unstall_valid", 32'(instr_valid), 0);
    chk("unstall_raddr", 32'(read_address), 4);

    // Wrap at the top of memory with an odd pc
    enable = 1'b0; jump_valid = 1'b1; jump_address = 4'hF;
    tick();
    jump_valid = 1'b0;
    chk("jidle_busy", 32'(busy), 0);
    chk("jidle_re", 32'(Read_Enable), 0);
    chk("jidle_raddr", 32'(read_address), 32'hF);
    mem[15] = 8'hAB; mem[0] = 8'hCD;
    enable = 1'b1;
    wait_valid(n);
    chk("wrap_instr", 32'(instruction), 32'hCDAB);
    chk("wrap_iaddr", 32'(instr_address), 32'hF);
    tick();
    chk("wrap_next_raddr", 32'(read_address), 1);

    // Jump during the high-byte read
    enable = 1'b0; jump_valid = 1'b1; jump_address = 4'h0;
    tick();
    jump_valid = 1'b0; enable = 1'b1;
    tick();
    chk("jm_lo_raddr", 32'(read_address), 0);
    tick();
    chk("jm_hi_raddr", 32'(read_address), 1);
    jump_valid = 1'b1; jump_address = 4'h8;
    tick();
    jump_valid = 1'b0;
    chk("jm_valid", 32'(instr_valid), 0);
    chk("jm_raddr8", 32'(read_address), 8);
    tick();
    chk("jm_raddr9", 32'(read_address), 9);
    wait_valid(n);
    chk("jm_iaddr", 32'(instr_address), 8);

    // Halt after the current instruction
    tick();
    chk("halt_lo_raddr", 32'(read_address), 32'hA);
    enable = 1'b0;
    wait_valid(n);
    chk("halt_iaddr", 32'(instr_address), 32'hA);
    tick();
    chk("halt_busy", 32'(busy), 0);
    chk("halt_valid", 32'(instr_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_re", 32'(Read_Enable), 0);
    end
    enable = 1'b1;
    tick();
    chk("resume_re", 32'(Read_Enable), 1);
    chk("resume_raddr", 32'(read_address), 32'hC);

    // Reset while an instruction is presented
    instr_ready = 1'b0;
    wait_valid(n);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_re", 32'(Read_Enable), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_iaddr", 32'(instr_address), 0);
    tick();
    reset_n = 1'b1; instr_ready = 1'b1;
    tick();
    chk("arst_restart_re", 32'(Read_Enable), 1);
    chk("arst_restart_raddr", 32'(read_address), 0);

    // Randomized run
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    tick();
    reset_n = 1'b1;
    rand_phase = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      enable       = ($urandom % 8) != 0;
      instr_ready  = ($urandom % 3) != 0;
      jump_valid   = ($urandom % 16) == 0;
      jump_address = 4'($urandom);
      tick();
    end
    enable = 1'b0; jump_valid = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rand_drained_busy", 32'(busy), 0);
    chk("rand_handshakes_seen", 32'(hs_rand > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the dual-port RAM's read port.
- Drives the RAM read port to fetch each instruction as two consecutive bytes: low byte at PC, high byte at PC+1.
- Assembles the two bytes into a 2*DATA_WIDTH instruction and presents it to the decoder over a valid/ready handshake.
- Supports halt/run and jump redirect. RAM Read_clock is tied to this block's clock.

Parameters:
- DATA_WIDTH, 8 (CPU_package): RAM word width; instruction width = 2*DATA_WIDTH.
- ADDRESS_WIDTH, 4 (CPU_package): RAM byte-address width; PC width.
- RESET_ADDRESS, 0: PC value after reset.

Ports:
- clock  input  1  single clock; rising edge; also drives RAM Read_clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = run (start new fetches), 0 = halt after current instruction.
- jump_valid  input  1  redirect PC this cycle.
- jump_address  input  ADDRESS_WIDTH  new PC; any value, odd allowed.
- read_address  output  ADDRESS_WIDTH  RAM read address.
- Read_Enable  output  1  RAM read enable.
- DATA_READ  input  DATA_WIDTH  RAM registered read data; valid the cycle after Read_Enable is sampled.
- instr_valid  output  1  instruction/instr_address valid.
- instr_ready  input  1  decoder accepts instruction.
- instruction  output  2*DATA_WIDTH  {high byte, low byte}.
- instr_address  output  ADDRESS_WIDTH  PC of the low byte of the presented instruction.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_ADDRESS, instr_valid=0, instruction=0, instr_address=RESET_ADDRESS, Read_Enable=0, read_address=RESET_ADDRESS, busy=0.
- States: IDLE, FETCH_LO, FETCH_HI, CAPTURE, VALID.
- Read_Enable and read_address are decoded from the registered state and pc:
  - FETCH_LO: Read_Enable=1, read_address=pc.
  - FETCH_HI: Read_Enable=1, read_address=pc+1, modulo 2^ADDRESS_WIDTH.
  - Otherwise: Read_Enable=0, read_address=pc.
- Transitions:
  - IDLE -> FETCH_LO when enable=1.
  - FETCH_LO -> FETCH_HI.
  - FETCH_HI -> CAPTURE; at this edge, low byte <= DATA_READ.
  - CAPTURE -> VALID; at this edge, high byte <= DATA_READ, instr_address <= pc, instr_valid <= 1.
  - VALID holds until instr_valid & instr_ready. On handshake: pc <= pc+2 (wraps), instr_valid <= 0, next state = FETCH_LO if enable else IDLE.
- Latency: instr_valid rises 3 clock edges after the first FETCH_LO edge. Sustained throughput is 1 instruction per 4 cycles with instr_ready held at 1.
- instruction and instr_address are stable while instr_valid=1 and instr_ready=0. No fetch is issued while stalled.
- enable=0 mid-fetch: the current instruction completes and is presented. After its handshake the block goes to IDLE. enable never aborts a fetch.
- jump_valid=1 (any state, highest priority):
  - pc <= jump_address, instr_valid <= 0, in-flight bytes discarded.
  - Next state = FETCH_LO if enable else IDLE.
  - If jump_valid coincides with a handshake, the presented instruction counts as accepted and the jump still sets pc; pc+2 is not applied.
- Wrap: pc+1 and pc+2 are computed modulo 2^ADDRESS_WIDTH. An instruction at pc=2^ADDRESS_WIDTH-1 takes its high byte from address 0.
- Reset asserted mid-operation: all state returns to reset values immediately. instr_valid drops without a handshake.

Test Plan:
- Preload RAM[0]=0x34, RAM[1]=0x12 via the write port; release reset; enable=1, instr_ready=1 -> Read_Enable on addr 0 then 1; instr_valid on 3rd edge with instruction=0x1234, instr_address=0; next fetch at addr 2.
- Stall: instr_ready=0 for 5 cycles with instr_valid=1 -> instruction and instr_address unchanged, Read_Enable=0 throughout; instr_ready=1 -> single handshake, pc advances by 2.
- Wrap/odd: RAM[0xF]=0xAB, RAM[0x0]=0xCD; jump_address=0xF -> instruction=0xCDAB, instr_address=0xF; next pc=0x1.
- Jump mid-fetch: assert jump_valid with jump_address=0x8 during FETCH_HI of addr 0 -> no instr_valid for addr 0; next reads are addr 8, 9; instr_address=0x8.
- Halt: drop enable during FETCH_LO -> instruction still delivered; after handshake busy=0, Read_Enable stays 0; re-assert enable -> fetch resumes at pc+2.
- Reset mid-VALID: pull reset_n low while instr_valid=1 -> instr_valid=0, Read_Enable=0, busy=0 asynchronously; after release, fetch restarts at RESET_ADDRESS.
